// File: rtl/clock_pkg.sv
// Shared encodings and BCD limits for the clock front-panel and datapath.
package clock_pkg;

  // Operating modes; encoding 3 is illegal.
  localparam logic [1:0] MODE_RUN       = 2'd0;
  localparam logic [1:0] MODE_SET_TIME  = 2'd1;
  localparam logic [1:0] MODE_SET_ALARM = 2'd2;

  // Field cursor positions.
  localparam logic [1:0] FLD_HOUR = 2'd0;
  localparam logic [1:0] FLD_MIN  = 2'd1;
  localparam logic [1:0] FLD_SEC  = 2'd2;

  // Upper limits of a two-digit BCD field.
  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  // A field with a non-decimal low digit or a value beyond its limit is
  // replaced by 00, so editing always starts from a legal value.
  function automatic logic [7:0] bcd_sanitize(input logic [7:0] val,
                                              input logic [7:0] max);
    if ((val[3:0] > 4'd9) || (val > max)) begin
      return 8'h00;
    end
    return val;
  endfunction

endpackage

// File: rtl/bcd2_step.sv
// Two-digit BCD increment/decrement with wrap between 00 and a field limit.
module bcd2_step (
  input  logic [7:0] val,
  input  logic [7:0] max,
  input  logic       up,
  input  logic       dn,
  output logic [7:0] next
);

  // One step up or down; both or neither requested leaves the value as is.
  always_comb begin
    // NOTE: every path starts from a default so no latch is inferred.
    next = val;
    if (up && !dn) begin
      if (val >= max) begin
        next = 8'h00;
      end else if (val[3:0] >= 4'd9) begin
        next = {val[7:4] + 4'd1, 4'd0};
      end else begin
        next = {val[7:4], val[3:0] + 4'd1};
      end
    end else if (dn && !up) begin
      if (val == 8'h00) begin
        next = max;
      end else if (val[3:0] == 4'd0) begin
        next = {val[7:4] - 4'd1, 4'd9};
      end else begin
        next = {val[7:4], val[3:0] - 4'd1};
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel controller: mode sequencing, field cursor, BCD editing of the
// manual time and alarm registers, and the timekeeper load strobe.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter logic [7:0]  RST_HOUR  = 8'h23,
  parameter logic [7:0]  RST_MIN   = 8'h57,
  parameter logic [15:0] ALARM_RST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_sel,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_alarm,
  input  logic [23:0] cur_time,
  output logic [23:0] manual_time,
  output logic [15:0] alarm_time,
  output logic [1:0]  mode,
  output logic [1:0]  field,
  output logic        load_time,
  output logic        alarm_en,
  output logic        blink_field
);

  logic [1:0]  mode_q, mode_d;
  logic [1:0]  field_q, field_d;
  logic [23:0] manual_q, manual_d;
  logic [15:0] alarm_q, alarm_d;
  logic        load_q, load_d;
  logic        alarm_en_q, alarm_en_d;

  logic [7:0]  step_val, step_max, step_next;

  // Route the field under the cursor, and its limit, into the single stepper.
  always_comb begin
    step_val = manual_q[23:16];
    step_max = HOUR_MAX;
    if (mode_q == MODE_SET_ALARM) begin
      if (field_q == FLD_MIN) begin
        step_val = alarm_q[7:0];
        step_max = MINSEC_MAX;
      end else begin
        step_val = alarm_q[15:8];
      end
    end else begin
      case (field_q)
        FLD_MIN: begin
          step_val = manual_q[15:8];
          step_max = MINSEC_MAX;
        end
        FLD_SEC: begin
          step_val = manual_q[7:0];
          step_max = MINSEC_MAX;
        end
        default: ;
      endcase
    end
  end

  bcd2_step u_step (
    .val  (step_val),
    .max  (step_max),
    .up   (btn_inc),
    .dn   (btn_dec),
    .next (step_next)
  );

  // Mode FSM, cursor and edit decode with priority mode > sel > inc/dec.
  always_comb begin
    mode_d     = mode_q;
    field_d    = field_q;
    manual_d   = manual_q;
    alarm_d    = alarm_q;
    load_d     = 1'b0;
    alarm_en_d = alarm_en_q;

    case (mode_q)
      MODE_RUN: begin
        if (btn_mode) begin
          mode_d   = MODE_SET_TIME;
          field_d  = FLD_HOUR;
          manual_d = {bcd_sanitize(cur_time[23:16], HOUR_MAX),
                      bcd_sanitize(cur_time[15:8],  MINSEC_MAX),
                      bcd_sanitize(cur_time[7:0],   MINSEC_MAX)};
        end else if (btn_alarm) begin
          alarm_en_d = ~alarm_en_q;
        end
      end

      MODE_SET_TIME: begin
        if (btn_mode) begin
          mode_d  = MODE_SET_ALARM;
          field_d = FLD_HOUR;
          load_d  = 1'b1;
        end else if (btn_sel) begin
          case (field_q)
            FLD_HOUR: field_d = FLD_MIN;
            FLD_MIN:  field_d = FLD_SEC;
            default:  field_d = FLD_HOUR;
          endcase
        end else if (btn_inc || btn_dec) begin
          case (field_q)
            FLD_HOUR: manual_d[23:16] = step_next;
            FLD_MIN:  manual_d[15:8]  = step_next;
            FLD_SEC:  manual_d[7:0]   = step_next;
            default:  ;
          endcase
        end
      end

      MODE_SET_ALARM: begin
        if (btn_mode) begin
          mode_d  = MODE_RUN;
          field_d = FLD_HOUR;
        end else if (btn_sel) begin
          // Alarm has no seconds: anything but HOUR goes back to HOUR.
          field_d = (field_q == FLD_HOUR) ? FLD_MIN : FLD_HOUR;
        end else if (btn_inc || btn_dec) begin
          if (field_q == FLD_MIN) begin
            alarm_d[7:0] = step_next;
          end else begin
            alarm_d[15:8] = step_next;
          end
        end
      end

      default: begin
        mode_d  = MODE_RUN;
        field_d = FLD_HOUR;
      end
    endcase
  end

  // State registers with synchronous reset; reset discards any edit in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      mode_q     <= MODE_RUN;
      field_q    <= FLD_HOUR;
      manual_q   <= {RST_HOUR, RST_MIN, 8'h00};
      alarm_q    <= ALARM_RST;
      load_q     <= 1'b0;
      alarm_en_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      field_q    <= field_d;
      manual_q   <= manual_d;
      alarm_q    <= alarm_d;
      load_q     <= load_d;
      alarm_en_q <= alarm_en_d;
    end
  end

  assign manual_time = manual_q;
  assign alarm_time  = alarm_q;
  assign mode        = mode_q;
  assign field       = field_q;
  assign load_time   = load_q;
  assign alarm_en    = alarm_en_q;
  // Blink whenever an edit mode is active.
  assign blink_field = (mode_q != MODE_RUN);

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed scoreboard bench for time_set_ctrl.
module tb_time_set_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_mode = 1'b0, btn_sel = 1'b0, btn_inc = 1'b0;
  logic        btn_dec = 1'b0, btn_alarm = 1'b0;
  logic [23:0] cur_time = 24'h235700;
  logic [23:0] manual_time;
  logic [15:0] alarm_time;
  logic [1:0]  mode, field;
  logic        load_time, alarm_en, blink_field;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [1:0]  mode;
    logic [1:0]  field;
    logic [23:0] mt;
    logic [15:0] at;
    logic        load;
    logic        en;
    logic        blink;
  } exp_t;

  exp_t sb[$];

  time_set_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .btn_mode    (btn_mode),
    .btn_sel     (btn_sel),
    .btn_inc     (btn_inc),
    .btn_dec     (btn_dec),
    .btn_alarm   (btn_alarm),
    .cur_time    (cur_time),
    .manual_time (manual_time),
    .alarm_time  (alarm_time),
    .mode        (mode),
    .field       (field),
    .load_time   (load_time),
    .alarm_en    (alarm_en),
    .blink_field (blink_field)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] m, input logic [1:0] f,
                              input logic [23:0] mt, input logic [15:0] at,
                              input logic ld, input logic en);
    exp_t e;
    e.tag   = "";
    e.mode  = m;
    e.field = f;
    e.mt    = mt;
    e.at    = at;
    e.load  = ld;
    e.en    = en;
    e.blink = (m != 2'd0);
    return e;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [23:0] obs,
                       input logic [23:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input string tag, input logic r, input logic m,
                      input logic s, input logic i, input logic d,
                      input logic a, input exp_t e);
    exp_t g;
    @(negedge clk);
    rst = r; btn_mode = m; btn_sel = s; btn_inc = i; btn_dec = d; btn_alarm = a;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0; btn_mode = 1'b0; btn_sel = 1'b0;
    btn_inc = 1'b0; btn_dec = 1'b0; btn_alarm = 1'b0;
    g = sb.pop_front();
    check({g.tag, ".mode"},  24'(mode),        24'(g.mode));
    check({g.tag, ".field"}, 24'(field),       24'(g.field));
    check({g.tag, ".mt"},    manual_time,      g.mt);
    check({g.tag, ".at"},    24'(alarm_time),  24'(g.at));
    check({g.tag, ".load"},  24'(load_time),   24'(g.load));
    check({g.tag, ".en"},    24'(alarm_en),    24'(g.en));
    check({g.tag, ".blink"}, 24'(blink_field), 24'(g.blink));
  endtask

  initial begin
    // Reset and entry snapshot.
    step("reset",      1, 0, 0, 0, 0, 0, mk(0, 0, 24'h235700, 16'h0000, 0, 0));
    cur_time = 24'h235700;
    step("enter_set",  0, 1, 0, 0, 0, 0, mk(1, 0, 24'h235700, 16'h0000, 0, 0));
    // Hour wrap both directions.
    step("hour_inc",   0, 0, 0, 1, 0, 0, mk(1, 0, 24'h005700, 16'h0000, 0, 0));
    step("hour_dec",   0, 0, 0, 0, 1, 0, mk(1, 0, 24'h235700, 16'h0000, 0, 0));
    step("sel_min",    0, 0, 1, 0, 0, 0, mk(1, 1, 24'h235700, 16'h0000, 0, 0));
    step("min_dec",    0, 0, 0, 0, 1, 0, mk(1, 1, 24'h235600, 16'h0000, 0, 0));
    // btn_mode wins over sel/inc in the same cycle; strobe follows.
    step("mode_prio",  0, 1, 1, 1, 0, 0, mk(2, 0, 24'h235600, 16'h0000, 1, 0));
    step("strobe_end", 0, 0, 0, 0, 0, 0, mk(2, 0, 24'h235600, 16'h0000, 0, 0));
    step("to_run",     0, 1, 0, 0, 0, 0, mk(0, 0, 24'h235600, 16'h0000, 0, 0));
    // Minute/second carry and borrow.
    cur_time = 24'h080900;
    step("enter2",     0, 1, 0, 0, 0, 0, mk(1, 0, 24'h080900, 16'h0000, 0, 0));
    step("sel_min2",   0, 0, 1, 0, 0, 0, mk(1, 1, 24'h080900, 16'h0000, 0, 0));
    step("min_carry",  0, 0, 0, 1, 0, 0, mk(1, 1, 24'h081000, 16'h0000, 0, 0));
    step("sel_sec",    0, 0, 1, 0, 0, 0, mk(1, 2, 24'h081000, 16'h0000, 0, 0));
    step("sec_borrow", 0, 0, 0, 0, 1, 0, mk(1, 2, 24'h081059, 16'h0000, 0, 0));
    step("sec_wrap",   0, 0, 0, 1, 0, 0, mk(1, 2, 24'h081000, 16'h0000, 0, 0));
    step("inc_dec",    0, 0, 0, 1, 1, 0, mk(1, 2, 24'h081000, 16'h0000, 0, 0));
    step("sel_prio",   0, 0, 1, 1, 0, 0, mk(1, 0, 24'h081000, 16'h0000, 0, 0));
    step("exit2",      0, 1, 0, 0, 0, 0, mk(2, 0, 24'h081000, 16'h0000, 1, 0));
    step("to_run2",    0, 1, 0, 0, 0, 0, mk(0, 0, 24'h081000, 16'h0000, 0, 0));
    // Load strobe with 08:15:30.
    cur_time = 24'h081529;
    step("enter3",     0, 1, 0, 0, 0, 0, mk(1, 0, 24'h081529, 16'h0000, 0, 0));
    step("sel3a",      0, 0, 1, 0, 0, 0, mk(1, 1, 24'h081529, 16'h0000, 0, 0));
    step("sel3b",      0, 0, 1, 0, 0, 0, mk(1, 2, 24'h081529, 16'h0000, 0, 0));
    step("sec_inc",    0, 0, 0, 1, 0, 0, mk(1, 2, 24'h081530, 16'h0000, 0, 0));
    step("load_hi",    0, 1, 0, 0, 0, 0, mk(2, 0, 24'h081530, 16'h0000, 1, 0));
    step("load_lo",    0, 0, 0, 0, 0, 0, mk(2, 0, 24'h081530, 16'h0000, 0, 0));
    // Alarm cursor and edit to 06:30.
    step("asel1",      0, 0, 1, 0, 0, 0, mk(2, 1, 24'h081530, 16'h0000, 0, 0));
    step("asel2",      0, 0, 1, 0, 0, 0, mk(2, 0, 24'h081530, 16'h0000, 0, 0));
    step("ahour_dec",  0, 0, 0, 0, 1, 0, mk(2, 0, 24'h081530, 16'h2300, 0, 0));
    step("ahour_inc",  0, 0, 0, 1, 0, 0, mk(2, 0, 24'h081530, 16'h0000, 0, 0));
    for (int i = 1; i <= 6; i++) begin
      step("ahour_up", 0, 0, 0, 1, 0, 0,
           mk(2, 0, 24'h081530, {to_bcd(i), 8'h00}, 0, 0));
    end
    step("asel_min",   0, 0, 1, 0, 0, 0, mk(2, 1, 24'h081530, 16'h0600, 0, 0));
    for (int i = 1; i <= 30; i++) begin
      step("amin_up",  0, 0, 0, 1, 0, 0,
           mk(2, 1, 24'h081530, {8'h06, to_bcd(i)}, 0, 0));
    end
    step("arun",       0, 1, 0, 0, 0, 0, mk(0, 0, 24'h081530, 16'h0630, 0, 0));
    step("arm",        0, 0, 0, 0, 0, 1, mk(0, 0, 24'h081530, 16'h0630, 0, 1));
    // btn_alarm ignored outside RUN; then reset mid-edit.
    cur_time = 24'h123456;
    step("enter4",     0, 1, 0, 0, 0, 0, mk(1, 0, 24'h123456, 16'h0630, 0, 1));
    step("alarm_ign",  0, 0, 0, 0, 0, 1, mk(1, 0, 24'h123456, 16'h0630, 0, 1));
    step("edit4",      0, 0, 0, 1, 0, 0, mk(1, 0, 24'h133456, 16'h0630, 0, 1));
    step("rst_mid",    1, 0, 0, 0, 0, 0, mk(0, 0, 24'h235700, 16'h0000, 0, 0));
    step("post_rst",   0, 0, 0, 0, 0, 0, mk(0, 0, 24'h235700, 16'h0000, 0, 0));
    // Sanitising: hour 2A and second 61 load as 00.
    cur_time = 24'h2A5961;
    step("sanitise",   0, 1, 0, 0, 0, 0, mk(1, 0, 24'h005900, 16'h0000, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Front-panel controller for the clock datapath.
- Sequences the operating mode: run, set time, set alarm.
- Walks a field cursor across hour/minute/second and applies BCD increment/decrement with correct wrap limits.
- Drives the manual time digits and the alarm registers.
- Issues a one-cycle load strobe that makes the 1 Hz timekeeper adopt the edited time.
- Sits between the debounced button logic and the timekeeper/alarm comparator.

Parameters:
- RST_HOUR, 8'h23, BCD hour loaded into the manual digits at reset.
- RST_MIN, 8'h57, BCD minute loaded into the manual digits at reset.
- ALARM_RST, 16'h0000, BCD hh:mm reset value of the alarm registers.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_mode  in  1  one-cycle pulse (debounced); advances the mode.
- btn_sel  in  1  one-cycle pulse; advances the field cursor.
- btn_inc  in  1  one-cycle pulse; increments the selected field.
- btn_dec  in  1  one-cycle pulse; decrements the selected field.
- btn_alarm  in  1  one-cycle pulse; toggles alarm_en (honoured in RUN only).
- cur_time  in  24  live BCD time {hourH,hourL,minH,minL,secH,secL} from the timekeeper.
- manual_time  out  24  edited BCD time, same packing as cur_time.
- alarm_time  out  16  BCD alarm {hourH,hourL,minH,minL}.
- mode  out  2  0=RUN, 1=SET_TIME, 2=SET_ALARM.
- field  out  2  0=HOUR, 1=MIN, 2=SEC.
- load_time  out  1  one-cycle strobe; timekeeper copies manual_time.
- alarm_en  out  1  alarm armed.
- blink_field  out  1  high when mode≠RUN; display blinks the field given by `field`.

Behaviour:
- Reset values (rst high at a clk edge):
  - mode=RUN, field=HOUR, load_time=0, alarm_en=0.
  - manual_time={RST_HOUR,RST_MIN,8'h00}; alarm_time=ALARM_RST.
  - Reset asserted mid-edit discards all edits; no load_time is issued.
- Input priority per cycle: btn_mode > btn_sel > btn_inc/btn_dec.
  - Lower-priority pulses arriving in the same cycle are dropped.
  - btn_inc and btn_dec together: no change.
- FSM, mode transitions on btn_mode:
  - RUN -> SET_TIME: manual_time <= cur_time (snapshot in the same edge), field <= HOUR.
  - SET_TIME -> SET_ALARM: load_time=1 on the following cycle only, field <= HOUR.
  - SET_ALARM -> RUN: no strobe; alarm_time keeps its edited value.
  - Encoding 3 is illegal and recovers to RUN on the next edge.
- btn_sel:
  - SET_TIME: cursor HOUR->MIN->SEC->HOUR.
  - SET_ALARM: cursor HOUR->MIN->HOUR; if field==SEC on entry to SET_ALARM it is forced to HOUR.
  - RUN: ignored.
- Edit target: SET_TIME edits manual_time; SET_ALARM edits alarm_time.
- Increment, BCD, 2 digits, result registered next edge:
  - Low digit 9 -> 0 with carry into the high digit.
  - Hour wraps 23 -> 00; minute/second wrap 59 -> 00.
- Decrement:
  - Low digit 0 -> 9 with borrow from the high digit.
  - Hour 00 -> 23; minute/second 00 -> 59.
- Only the selected field changes; other fields and the other register set are untouched.
  - No carry between fields (59 -> 00 on minutes does not change hours).
- Out-of-range incoming digits (e.g. cur_time hour 0x2A) are sanitised on the snapshot: any field exceeding its limit is loaded as 00.
- btn_alarm: in RUN toggles alarm_en; ignored in other modes.
- load_time:
  - Exactly one cycle per SET_TIME exit.
  - Never asserted in the same cycle as a mode change into SET_TIME.
  - manual_time is stable while load_time is high.
- Latency: every button effect is visible on outputs 1 clk after the pulse edge.
- blink_field is combinational from mode.

Decomposition:
- Shared package clock_pkg holds:
  - mode encodings MODE_RUN/MODE_SET_TIME/MODE_SET_ALARM;
  - field encodings FLD_HOUR/FLD_MIN/FLD_SEC;
  - BCD limits HOUR_MAX=8'h23, MINSEC_MAX=8'h59.
- One combinational sub-module, bcd2_step: inputs val[7:0], max[7:0], up, dn; output next[7:0] with wrap.
  - Instantiated once and muxed onto the selected field.

Test Plan:
- Entry snapshot: reset, cur_time=23:57:00, btn_mode -> mode=1, field=0, manual_time=0x235700, blink_field=1.
- Hour wrap: in SET_TIME with hour 23, btn_inc -> hour 00, minutes unchanged; btn_dec -> 23.
- Minute/second BCD carry: select MIN at 09, btn_inc -> 10; set SEC at 00, btn_dec -> 59, minutes unchanged; btn_inc+btn_dec together -> no change.
- Load strobe: in SET_TIME with manual_time=0x081530, btn_mode -> mode=2; load_time high exactly one cycle after that edge, manual_time=0x081530 during it.
- Alarm edit: in SET_ALARM, btn_sel twice -> field returns to HOUR; set alarm to 06:30; btn_mode -> RUN; btn_alarm -> alarm_en=1; alarm_time=0x0630, manual_time unchanged.
- Reset mid-edit and sanitising: assert rst while mode=1 -> next cycle mode=0, manual_time=0x235700, load_time never high; enter SET_TIME with cur_time hour=0x2A -> snapshot hour=00.
